// File: rtl/npc_predict_unit_pkg.sv
// npc_predict_unit_pkg: next-PC branch codes, BHT counter encodings and saturating update
package npc_predict_unit_pkg;
  localparam logic [4:0] PC4_NPC        = 5'd0;
  localparam logic [4:0] B_TRANSFER_NPC = 5'd1;
  localparam logic [4:0] J_TRANSFER_NPC = 5'd2;
  localparam logic [4:0] JR_NPC         = 5'd3;
  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;
  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
    return taken ? (c == BHT_ST ? c : c + 2'd1) : (c == BHT_SNT ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/npc_predict_unit_if.sv
// npc_predict_unit_if: pipeline-side D/E signals and fetch PC outputs of the predictor
interface npc_predict_unit_if;
  logic        stall;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [4:0]  D_branch;
  logic [31:0] D_offset;
  logic [25:0] D_imm26;
  logic [31:0] D_ra;
  logic        D_is_call;
  logic        D_is_ret;
  logic        D_pred_taken;
  logic [31:0] D_pred_target;
  logic        E_valid;
  logic [31:0] E_PC;
  logic        E_is_cond;
  logic        E_taken;
  logic [31:0] E_target;
  logic        E_pred_taken;
  logic [31:0] E_pred_target;
  logic        flush_fd;
  modport master (
    output stall, D_PC, D_branch, D_offset, D_imm26, D_ra, D_is_call, D_is_ret,
           E_valid, E_PC, E_is_cond, E_taken, E_target, E_pred_taken, E_pred_target,
    input  F_PC, D_pred_taken, D_pred_target, flush_fd
  );
  modport slave (
    input  stall, D_PC, D_branch, D_offset, D_imm26, D_ra, D_is_call, D_is_ret,
           E_valid, E_PC, E_is_cond, E_taken, E_target, E_pred_taken, E_pred_target,
    output F_PC, D_pred_taken, D_pred_target, flush_fd
  );
endinterface

// File: rtl/npc_predict_unit_ras.sv
// ras_stack: circular return-address stack; full push overwrites oldest, empty pop is ignored
module ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] top,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] sp;
  logic [AW:0]   count;
  logic          do_pop;
  assign empty  = count == '0;
  assign do_pop = pop & !empty;
  assign top    = mem[sp - 1'b1];
  // pointer/occupancy; pop+push together replaces the top in place
  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
    end else if (push & !do_pop) begin
      sp    <= sp + 1'b1;
      count <= count == FULL ? count : count + 1'b1;
    end else if (do_pop & !push) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end
  // entry storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? sp - 1'b1 : sp] <= din;
  end
endmodule

// File: rtl/npc_predict_unit.sv
// npc_predict_unit: fetch PC register with D-stage BHT/jump/RAS prediction and E-stage repair
module npc_predict_unit
  import npc_predict_unit_pkg::*;
#(
  parameter int          BHT_ENTRIES = 64,
  parameter int          RAS_DEPTH   = 8,
  parameter logic [31:0] RESET_PC    = 32'h3000
) (
  input logic              clk,
  input logic              reset,
  npc_predict_unit_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0]    bht [BHT_ENTRIES];
  logic [31:0]   f_pc, correct_pc, ras_top, pred_target;
  logic          mispredict, pred_taken, b_taken, is_j, is_jr, ras_empty, ras_upd;
  logic [IW-1:0] d_idx, e_idx;
  assign d_idx = bus.D_PC[IW+1:2];
  assign e_idx = bus.E_PC[IW+1:2];
  // E-stage resolution and D-stage target selection
  always_comb begin
    correct_pc  = bus.E_taken ? bus.E_target : bus.E_PC + 32'd8;
    mispredict  = bus.E_valid & ((bus.E_pred_taken != bus.E_taken) |
                  (bus.E_taken & (bus.E_pred_target != bus.E_target)));
    b_taken     = (bus.D_branch == B_TRANSFER_NPC) & bht[d_idx][1];
    is_j        = bus.D_branch == J_TRANSFER_NPC;
    is_jr       = bus.D_branch == JR_NPC;
    pred_taken  = b_taken | is_j | is_jr;
    pred_target = b_taken ? bus.D_PC + 32'd4 + (bus.D_offset << 2) :
                  is_j    ? {bus.D_PC[31:28], bus.D_imm26, 2'b00} :
                  is_jr   ? ((bus.D_is_ret & !ras_empty) ? ras_top : bus.D_ra) :
                            bus.D_PC + 32'd8;
    ras_upd     = !bus.stall & !mispredict;
  end
  assign bus.F_PC          = f_pc;
  assign bus.flush_fd      = !reset & mispredict;
  assign bus.D_pred_taken  = !reset & pred_taken;
  assign bus.D_pred_target = reset ? '0 : pred_target;
  // fetch PC: E repair beats stall, stall beats D prediction
  always_ff @(posedge clk) begin
    if (reset) f_pc <= RESET_PC;
    else f_pc <= mispredict ? correct_pc : bus.stall ? f_pc : pred_taken ? pred_target : f_pc + 32'd4;
  end
  // BHT trains from resolved conditional branches; same-cycle D read sees the old counter
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_WNT;
    else if (bus.E_valid & bus.E_is_cond) bht[e_idx] <= bht_next(bht[e_idx], bus.E_taken);
  end
  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_upd & bus.D_is_call),
    .pop   (ras_upd & bus.D_is_ret),
    .din   (bus.D_PC + 32'd8),
    .top   (ras_top),
    .empty (ras_empty)
  );
endmodule
